hsstlp_apb_cfg_master: RTL and testbench
========================================

Name: hsstlp_apb_cfg_master

Overview:
- Command-to-APB master that generates the p_cfg_* fabric-side bus consumed by the HSSTLP APB bridge (addr[15:12] selects channel 0-3 / PLL0 / PLL1).
- Accepts single read, write or read-modify-write (RMW) commands over a valid/ready interface and returns one response per command.
- Guards the bus against unmapped regions (the bridge never returns ready there) and against stalled slaves via a timeout.

Parameters:
- TIMEOUT_CYC, 255, ACCESS-phase cycles to wait for p_cfg_ready before aborting; 0 disables the timeout.
- MAX_REGION, 4'h5, highest legal addr[15:12]; larger values are rejected.

Ports:
- p_cfg_clk  in  1  configuration clock.
- p_cfg_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write, 0=read (ignored when cmd_rmw=1).
- cmd_rmw  in  1  read-modify-write.
- cmd_addr  in  16  {region[3:0], offset[11:0]}.
- cmd_wdata  in  8  write data / RMW new bits.
- cmd_mask  in  8  RMW bit mask (1 = take cmd_wdata bit).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  8  read data (RMW: original value read).
- rsp_err  out  1  1 = unmapped region or timeout.
- p_cfg_psel  out  1  APB select.
- p_cfg_enable  out  1  APB enable.
- p_cfg_write  out  1  APB direction.
- p_cfg_addr  out  16  APB address.
- p_cfg_wdata  out  8  APB write data.
- p_cfg_ready  in  1  APB ready from bridge.
- p_cfg_rdata  in  8  APB read data from bridge.

Behaviour:
- Reset (async, p_cfg_rst_n=0):
  - State IDLE.
  - All outputs 0; cmd_ready 0 until the first clock after deassertion.
  - Timeout counter 0; latched command cleared.
- States: IDLE, SETUP, ACCESS, MODIFY, RESP.
- IDLE:
  - cmd_ready=1.
  - On valid&ready, latch addr/wdata/mask/type.
  - If addr[15:12] > MAX_REGION, go to RESP with rsp_err=1, rsp_rdata=0; no APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel=1, enable=0; addr and wdata driven from the latched copy.
  - write=1 for a write, or for the second pass of RMW; otherwise 0.
  - Go to ACCESS.
- ACCESS:
  - psel=1, enable=1; address, data and write held stable.
  - Timeout counter increments each cycle in which ready=0.
  - On p_cfg_ready=1:
    - Read: capture p_cfg_rdata.
    - RMW first pass: capture rdata and go to MODIFY.
    - Otherwise go to RESP with err=0.
  - Counter reaches TIMEOUT_CYC (TIMEOUT_CYC≠0) with ready still 0: go to RESP with err=1, rdata=0.
  - psel and enable drop on the next cycle; the counter clears on every SETUP entry.
- MODIFY (1 cycle):
  - psel=0, enable=0.
  - wdata_lat = (rd & ~mask) | (wdata & mask).
  - Go to SETUP with write=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held until rsp_ready.
  - On rsp_valid&rsp_ready, return to IDLE; cmd_ready is 0 throughout RESP.
- Latency, plain read/write, command accepted at edge T0 and ready=1 on the first ACCESS cycle:
  - SETUP at T1, ACCESS at T2, rsp_valid at T3.
  - Each cycle of slave wait-state adds one cycle.
- Latency, RMW with zero wait states: two APB transfers plus MODIFY; rsp_valid at T6.
- psel never falls between SETUP and ACCESS of the same transfer.
- enable is never 1 without psel.
- Outputs are registered, with no combinational path from p_cfg_ready to any output.
- rsp_valid=1 together with rsp_ready=1 while cmd_valid=1: the response completes this cycle; the new command is accepted the next cycle in IDLE.
- A RMW timeout on the read pass aborts the whole command; no write pass is issued.

Decomposition:
- Package hsstlp_cfg_pkg:
  - State encoding.
  - Region constants: REG_CH0=0 … REG_CH3=3, REG_PLL0=4, REG_PLL1=5.
  - APB address/data widths.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write addr 0x2034, data 0xA5, slave ready on first ACCESS cycle:
  - psel=1 at T1, enable=1 at T2, write=1, addr=0x2034, wdata=0xA5.
  - rsp_valid at T3, err=0.
- Read addr 0x4010, slave inserts 3 wait states then returns 0x3C:
  - enable held 4 cycles.
  - rsp_rdata=0x3C, err=0, rsp_valid at T6.
- RMW addr 0x1008, wdata 0x0F, mask 0x0C, slave read value 0xF0:
  - Second transfer has write=1, wdata=0xFC.
  - rsp_rdata=0xF0.
- Read addr 0x7000:
  - No psel ever asserted.
  - rsp_valid at T1 with err=1, rdata=0.
- TIMEOUT_CYC=4, slave never ready:
  - Exactly 4 ACCESS cycles, then psel and enable drop to 0.
  - rsp_err=1.
  - Next command is accepted normally.
- Assert p_cfg_rst_n=0 mid-ACCESS:
  - psel, enable and rsp_valid go to 0 immediately (asynchronous).
  - After release, cmd_ready=1 and no response is emitted for the aborted command.

Source files
------------

// File: rtl/hsstlp_cfg_pkg.sv
// Shared definitions for the HSSTLP configuration-bus master: state codes,
// region map, bus widths and the read-modify-write merge rule.
package hsstlp_cfg_pkg;

   localparam int APB_ADDR_W = 16;
   localparam int APB_DATA_W = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_MODIFY = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   localparam logic [3:0] REG_CH0  = 4'd0;
   localparam logic [3:0] REG_CH1  = 4'd1;
   localparam logic [3:0] REG_CH2  = 4'd2;
   localparam logic [3:0] REG_CH3  = 4'd3;
   localparam logic [3:0] REG_PLL0 = 4'd4;
   localparam logic [3:0] REG_PLL1 = 4'd5;

   // Mask bits set take the new value, cleared bits keep the value read back.
   function automatic logic [APB_DATA_W-1:0] rmw_merge(
      input logic [APB_DATA_W-1:0] old_val,
      input logic [APB_DATA_W-1:0] new_bits,
      input logic [APB_DATA_W-1:0] mask
   );
      return (old_val & ~mask) | (new_bits & mask);
   endfunction

endpackage

// File: rtl/hsstlp_apb_cfg_master.sv
// Command-to-APB master for the HSSTLP p_cfg_* bus: single read, write or
// read-modify-write per command, with region guard and slave timeout.
module hsstlp_apb_cfg_master
   import hsstlp_cfg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [3:0]  MAX_REGION  = REG_PLL1
) (
   input  logic                  p_cfg_clk,
   input  logic                  p_cfg_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic                  cmd_rmw,
   input  logic [APB_ADDR_W-1:0] cmd_addr,
   input  logic [APB_DATA_W-1:0] cmd_wdata,
   input  logic [APB_DATA_W-1:0] cmd_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [APB_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  p_cfg_psel,
   output logic                  p_cfg_enable,
   output logic                  p_cfg_write,
   output logic [APB_ADDR_W-1:0] p_cfg_addr,
   output logic [APB_DATA_W-1:0] p_cfg_wdata,
   input  logic                  p_cfg_ready,
   input  logic [APB_DATA_W-1:0] p_cfg_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [APB_ADDR_W-1:0] addr_q, addr_d;
   logic [APB_DATA_W-1:0] wdata_q, wdata_d;
   logic [APB_DATA_W-1:0] mask_q, mask_d;
   logic [APB_DATA_W-1:0] rdata_q, rdata_d;
   logic                  wr_q, wr_d;
   logic                  rmw_q, rmw_d;
   logic                  pass2_q, pass2_d;
   logic                  err_q, err_d;
   logic                  psel_q, psel_d;
   logic                  enable_q, enable_d;
   logic                  pwrite_q, pwrite_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      wr_d    = wr_q;
      rmw_d   = rmw_q;
      pass2_d = pass2_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               mask_d  = cmd_mask;
               wr_d    = cmd_write;
               rmw_d   = cmd_rmw;
               pass2_d = 1'b0;
               rdata_d = '0;
               cnt_d   = '0;
               if (cmd_addr[15:12] > MAX_REGION) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (p_cfg_ready) begin
               if (rmw_q && !pass2_q) begin
                  rdata_d = p_cfg_rdata;
                  state_d = ST_MODIFY;
               end else begin
                  if (!rmw_q && !wr_q) rdata_d = p_cfg_rdata;
                  state_d = ST_RESP;
               end
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
               // A stalled read pass of an RMW ends here too: no write pass follows.
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_MODIFY: begin
            wdata_d = rmw_merge(rdata_q, wdata_q, mask_q);
            pass2_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_SETUP;
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bus and handshake outputs are registered from the next state.
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      enable_d    = (state_d == ST_ACCESS);
      pwrite_d    = psel_d && (pass2_d || (wr_d && !rmw_d));
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge p_cfg_clk or negedge p_cfg_rst_n) begin
      if (!p_cfg_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         rdata_q     <= '0;
         wr_q        <= 1'b0;
         rmw_q       <= 1'b0;
         pass2_q     <= 1'b0;
         err_q       <= 1'b0;
         psel_q      <= 1'b0;
         enable_q    <= 1'b0;
         pwrite_q    <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         rdata_q     <= rdata_d;
         wr_q        <= wr_d;
         rmw_q       <= rmw_d;
         pass2_q     <= pass2_d;
         err_q       <= err_d;
         psel_q      <= psel_d;
         enable_q    <= enable_d;
         pwrite_q    <= pwrite_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_err      = err_q;
   assign p_cfg_psel   = psel_q;
   assign p_cfg_enable = enable_q;
   assign p_cfg_write  = pwrite_q;
   assign p_cfg_addr   = addr_q;
   assign p_cfg_wdata  = wdata_q;

endmodule

// File: tb/tb_hsstlp_apb_cfg_master.sv
// Bench for hsstlp_apb_cfg_master: directed and random commands against a
// register-file reference model, plus reset-abort behaviour.
module tb_hsstlp_apb_cfg_master;

   localparam int TO = 4;

   logic        p_cfg_clk;
   logic        p_cfg_rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_rmw;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [7:0]  cmd_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        p_cfg_psel;
   logic        p_cfg_enable;
   logic        p_cfg_write;
   logic [15:0] p_cfg_addr;
   logic [7:0]  p_cfg_wdata;
   logic        p_cfg_ready;
   logic [7:0]  p_cfg_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   hsstlp_apb_cfg_master #(.TIMEOUT_CYC(TO), .MAX_REGION(4'h5)) dut (
      .p_cfg_clk    (p_cfg_clk),
      .p_cfg_rst_n  (p_cfg_rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_rmw      (cmd_rmw),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .cmd_mask     (cmd_mask),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .p_cfg_psel   (p_cfg_psel),
      .p_cfg_enable (p_cfg_enable),
      .p_cfg_write  (p_cfg_write),
      .p_cfg_addr   (p_cfg_addr),
      .p_cfg_wdata  (p_cfg_wdata),
      .p_cfg_ready  (p_cfg_ready),
      .p_cfg_rdata  (p_cfg_rdata)
   );

   initial p_cfg_clk = 1'b0;
   always #5 p_cfg_clk = ~p_cfg_clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One full command: the slave answers after `waits` wait states (or never
   // when hang=1), the response is held for `rdly` cycles before it is taken.
   task automatic run_cmd(input bit rmw, input bit wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] mk,
                          input int waits, input bit hang, input int rdly);
      bit          mapped, done, seen, prev_psel, prev_setup;
      logic [7:0]  e_rd, e_new;
      bit          e_err;
      int          e_lat, e_nx, e_psel;
      int          c, acc, nx, psel_n, enb_n, bad, hold, held, rsp_c;
      logic [7:0]  r_rd;
      logic        r_err;
      logic [15:0] s_addr;
      logic        s_wr;
      logic [7:0]  s_wd;
      logic        xw [0:3];
      logic [15:0] xa [0:3];
      logic [7:0]  xd [0:3];

      mapped = (addr[15:12] <= 4'd5);
      e_new  = ref_mem[addr];
      e_err  = 1'b0;
      e_rd   = 8'h00;
      if (!mapped) begin
         e_err = 1'b1; e_nx = 0; e_lat = 1; e_psel = 0;
      end else if (hang) begin
         e_err = 1'b1; e_nx = 0; e_lat = 2 + TO; e_psel = 1 + TO;
      end else if (rmw) begin
         e_rd = ref_mem[addr];
         for (int i = 0; i < 8; i++) e_new[i] = mk[i] ? wd[i] : e_rd[i];
         ref_mem[addr] = e_new;
         e_nx = 2; e_lat = 6 + 2 * waits; e_psel = 2 * (2 + waits);
      end else if (wr) begin
         e_new = wd;
         ref_mem[addr] = wd;
         e_nx = 1; e_lat = 3 + waits; e_psel = 2 + waits;
      end else begin
         e_rd = ref_mem[addr];
         e_nx = 1; e_lat = 3 + waits; e_psel = 2 + waits;
      end

      for (int i = 0; i < 4; i++) begin
         xw[i] = 1'b0; xa[i] = 16'h0; xd[i] = 8'h0;
      end
      c = 0; acc = 0; nx = 0; psel_n = 0; enb_n = 0; bad = 0; hold = 0; held = 0;
      rsp_c = -1; done = 1'b0; seen = 1'b0; prev_psel = 1'b0; prev_setup = 1'b0;
      r_rd = 8'h00; r_err = 1'b0; s_addr = 16'h0; s_wr = 1'b0; s_wd = 8'h0;

      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_rmw = rmw; cmd_write = wr;
      cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk;
      @(negedge p_cfg_clk);
      cmd_valid = 1'b0;
      cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom); cmd_mask = 8'($urandom);
      cmd_write = 1'($urandom); cmd_rmw = 1'($urandom);
      c = 1;
      while (!done && c < 40) begin
         if (p_cfg_enable && !p_cfg_psel) bad++;
         if (p_cfg_enable && !prev_psel) bad++;
         if (prev_setup && !(p_cfg_psel && p_cfg_enable)) bad++;
         if (p_cfg_psel) psel_n++;
         if (p_cfg_psel && !p_cfg_enable) begin
            s_addr = p_cfg_addr; s_wr = p_cfg_write; s_wd = p_cfg_wdata;
         end
         if (p_cfg_enable) begin
            enb_n++;
            acc++;
            if (p_cfg_addr !== s_addr || p_cfg_write !== s_wr || p_cfg_wdata !== s_wd) bad++;
            if (!hang && acc > waits) begin
               p_cfg_ready = 1'b1;
               if (p_cfg_write) mem[p_cfg_addr] = p_cfg_wdata;
               else p_cfg_rdata = mem[p_cfg_addr];
               if (nx < 4) begin
                  xw[nx] = p_cfg_write; xa[nx] = p_cfg_addr; xd[nx] = p_cfg_wdata;
               end
               nx++;
               acc = 0;
            end else begin
               p_cfg_ready = 1'b0;
               p_cfg_rdata = 8'($urandom);
            end
         end else begin
            p_cfg_ready = 1'($urandom);
            p_cfg_rdata = 8'($urandom);
         end
         if (rsp_valid) begin
            if (!seen) begin
               seen = 1'b1; rsp_c = c; r_rd = rsp_rdata; r_err = rsp_err;
            end else if (rsp_rdata !== r_rd || rsp_err !== r_err) begin
               hold++;
            end
            if (cmd_ready || p_cfg_psel || p_cfg_enable) bad++;
            if (held == rdly) begin
               rsp_ready = 1'b1;
               done = 1'b1;
            end
            held++;
         end
         prev_setup = p_cfg_psel && !p_cfg_enable;
         prev_psel  = p_cfg_psel;
         @(negedge p_cfg_clk);
         c++;
      end
      rsp_ready   = 1'b0;
      p_cfg_ready = 1'b0;

      check("rsp_seen", done, 1);
      check("rsp_latency", rsp_c, e_lat);
      check("rsp_rdata", r_rd, e_rd);
      check("rsp_err", r_err, e_err);
      check("xfer_count", nx, e_nx);
      check("psel_cycles", psel_n, e_psel);
      check("protocol", bad, 0);
      check("rsp_hold", hold, 0);
      check("slave_mem", mem[addr], ref_mem[addr]);
      if (hang && mapped) check("timeout_access_cycles", enb_n, TO);
      if (e_nx >= 1) begin
         check("x0_addr", xa[0], addr);
         check("x0_write", xw[0], (wr && !rmw) ? 1 : 0);
         if (wr && !rmw) check("x0_wdata", xd[0], wd);
      end
      if (e_nx == 2) begin
         check("x1_addr", xa[1], addr);
         check("x1_write", xw[1], 1);
         check("x1_wdata", xd[1], e_new);
      end
   endtask

   initial begin
      int bad;
      for (int a = 0; a < 65536; a++) begin
         mem[a]     = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
         ref_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
      end
      p_cfg_rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_rmw = 1'b0;
      cmd_addr = 16'h0; cmd_wdata = 8'h0; cmd_mask = 8'h0;
      rsp_ready = 1'b0; p_cfg_ready = 1'b0; p_cfg_rdata = 8'h0;

      repeat (2) @(negedge p_cfg_clk);
      check("reset_outputs",
            {p_cfg_psel, p_cfg_enable, p_cfg_write, rsp_valid, rsp_err, cmd_ready,
             p_cfg_addr, p_cfg_wdata, rsp_rdata}, 0);
      p_cfg_rst_n = 1'b1;
      #1 check("cmd_ready_before_clock", cmd_ready, 0);
      @(negedge p_cfg_clk);

      // Directed cases from the test plan.
      run_cmd(1'b0, 1'b1, 16'h2034, 8'hA5, 8'h00, 0, 1'b0, 0);
      mem[16'h4010] = 8'h3C; ref_mem[16'h4010] = 8'h3C;
      run_cmd(1'b0, 1'b0, 16'h4010, 8'h00, 8'h00, 3, 1'b0, 1);
      mem[16'h1008] = 8'hF0; ref_mem[16'h1008] = 8'hF0;
      run_cmd(1'b1, 1'b0, 16'h1008, 8'h0F, 8'h0C, 0, 1'b0, 0);
      check("rmw_result", mem[16'h1008], 8'hFC);
      run_cmd(1'b0, 1'b0, 16'h7000, 8'h00, 8'h00, 0, 1'b0, 0);
      run_cmd(1'b0, 1'b0, 16'h0123, 8'h00, 8'h00, 0, 1'b1, 0);
      run_cmd(1'b0, 1'b1, 16'h5FFF, 8'h66, 8'h00, 1, 1'b0, 2);
      run_cmd(1'b1, 1'b0, 16'h3010, 8'hFF, 8'hFF, 0, 1'b1, 0);
      run_cmd(1'b0, 1'b0, 16'h3010, 8'h00, 8'h00, 2, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ra;
         ra = {4'($urandom_range(0, 7)), 12'($urandom_range(0, 15))};
         run_cmd(1'($urandom), 1'($urandom), ra, 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 2)));
      end

      // Reset in the middle of an ACCESS phase.
      cmd_valid = 1'b1; cmd_rmw = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0100;
      @(negedge p_cfg_clk);
      cmd_valid = 1'b0;
      @(negedge p_cfg_clk);
      check("pre_reset_access", {p_cfg_psel, p_cfg_enable}, 2'b11);
      #2 p_cfg_rst_n = 1'b0;
      #1 check("async_reset_clears", {p_cfg_psel, p_cfg_enable, rsp_valid, cmd_ready}, 0);
      @(negedge p_cfg_clk);
      p_cfg_rst_n = 1'b1;
      @(negedge p_cfg_clk);
      check("cmd_ready_after_reset", cmd_ready, 1);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid || p_cfg_psel) bad++;
         @(negedge p_cfg_clk);
      end
      check("no_resp_after_abort", bad, 0);
      run_cmd(1'b0, 1'b0, 16'h0100, 8'h00, 8'h00, 0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
